// File: rtl/heater_supervisor.sv
// heater_supervisor: staggered heater turn-on, per-channel error recovery and fault latching
module heater_supervisor #(
    parameter int N         = 32,
    parameter int STAGGER   = 256,
    parameter int CLR_PULSE = 4,
    parameter int HOLDOFF   = 1024,
    parameter int MAX_RETRY = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_enable,
    input  logic [N-1:0] fault_clear,
    input  logic [N-1:0] heater_error,
    output logic [N-1:0] heater_enable,
    output logic [N-1:0] heater_err_clear,
    output logic [N-1:0] fault,
    output logic         busy
);
    localparam int SW   = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int RMAX = (CLR_PULSE > HOLDOFF) ? CLR_PULSE : HOLDOFF;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    typedef enum logic {S_IDLE, S_WAIT} s_state_t;
    typedef enum logic [1:0] {R_IDLE, R_CLEAR, R_HOLD} r_state_t;

    s_state_t      s_state, s_next;
    r_state_t      r_state, r_next;
    logic [SW-1:0] s_cnt, s_cnt_next;
    logic [RW-1:0] r_cnt, r_cnt_next;
    logic [N-1:0]  r_ch, r_ch_next;
    logic [N-1:0]  recov_pend, pend_next;
    logic [N-1:0]  en_next, clr_next, fault_next;
    logic [2:0]    retry_cnt [N];
    logic [2:0]    retry_next [N];
    logic [N-1:0]  in_recov, elig, err_ev, fc_ev, s_pick, r_pick;
    logic          s_go, r_take;

    // Channel qualification shared by both engines; x & -x isolates the lowest set bit
    always_comb begin
        in_recov = (r_state != R_IDLE) ? r_ch : '0;
        elig     = req_enable & ~heater_enable & ~fault & ~recov_pend & ~in_recov;
        err_ev   = heater_error & heater_enable;
        fc_ev    = fault_clear & fault;
        s_pick   = elig & (~elig + 1'b1);
        r_pick   = recov_pend & (~recov_pend + 1'b1);
    end

    // Stagger engine: a new channel may start once the spacing counter has run out
    always_comb begin
        s_go       = (s_cnt == '0) && (|elig);
        s_cnt_next = s_go ? SW'(STAGGER - 1) : (s_cnt == '0) ? s_cnt : s_cnt - 1'b1;
        s_next     = (s_go || s_cnt != '0) ? S_WAIT : S_IDLE;
    end

    // Recovery engine: clear strobe on one channel, then holdoff before it may restart
    always_comb begin
        r_next     = r_state;
        r_cnt_next = r_cnt;
        r_ch_next  = r_ch;
        r_take     = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (|recov_pend) begin
                    r_take     = 1'b1;
                    r_ch_next  = r_pick;
                    r_cnt_next = RW'(CLR_PULSE - 1);
                    r_next     = R_CLEAR;
                end
            end
            R_CLEAR: begin
                r_cnt_next = (r_cnt == '0) ? RW'(HOLDOFF - 1) : r_cnt - 1'b1;
                r_next     = (r_cnt == '0) ? R_HOLD : R_CLEAR;
            end
            R_HOLD: begin
                r_cnt_next = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
                r_next     = (r_cnt == '0) ? R_IDLE : R_HOLD;
            end
            default: r_next = R_IDLE;
        endcase
        clr_next = (r_next == R_CLEAR) ? r_ch_next : '0;
    end

    // Per-channel enable, retry count, fault latch and pending-recovery updates
    always_comb begin
        en_next    = (heater_enable & req_enable & ~err_ev) | (s_go ? s_pick : '0);
        pend_next  = (recov_pend & ~(r_take ? r_pick : '0)) | err_ev | fc_ev;
        fault_next = fault;
        for (int i = 0; i < N; i++) begin
            retry_next[i] = fc_ev[i] ? 3'd0 :
                            err_ev[i] ? ((retry_cnt[i] == 3'd7) ? 3'd7 : retry_cnt[i] + 3'd1) :
                            req_enable[i] ? retry_cnt[i] : 3'd0;
            fault_next[i] = fc_ev[i] ? 1'b0 :
                            (err_ev[i] && retry_next[i] == 3'(MAX_RETRY)) ? 1'b1 : fault[i];
        end
    end

    // Stagger state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_state <= S_IDLE;
            s_cnt   <= '0;
        end else begin
            s_state <= s_next;
            s_cnt   <= s_cnt_next;
        end
    end

    // Recovery state register and the registered clear strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= R_IDLE;
            r_cnt            <= '0;
            r_ch             <= '0;
            heater_err_clear <= '0;
        end else begin
            r_state          <= r_next;
            r_cnt            <= r_cnt_next;
            r_ch             <= r_ch_next;
            heater_err_clear <= clr_next;
        end
    end

    // Channel registers; reset drops every enable and fault immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            heater_enable <= '0;
            fault         <= '0;
            recov_pend    <= '0;
            for (int i = 0; i < N; i++) retry_cnt[i] <= '0;
        end else begin
            heater_enable <= en_next;
            fault         <= fault_next;
            recov_pend    <= pend_next;
            for (int i = 0; i < N; i++) retry_cnt[i] <= retry_next[i];
        end
    end

    assign busy = (s_state != S_IDLE) | (r_state != R_IDLE) | (|recov_pend);

endmodule
